// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encodings and the latched command payload for the ALU command stage.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB  = 2'b01;
    localparam logic [OP_W-1:0] OP_INC  = 2'b10;
    localparam logic [OP_W-1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
    } alu_cmd_t;

endpackage

// File: rtl/alu.sv
// 4-bit ALU: add (A+B+CIN), subtract (A-B-CIN), increment A, pass A.
// CF is the adder carry-out (for subtract 1 means no borrow); OF is signed overflow.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] s,
    output logic              of,
    output logic              cf
);

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              c;
    logic [DATA_W:0]   sum;

    // Map every operation onto a single adder, then pick the result and flags.
    always_comb begin
        x = a;
        y = '0;
        c = 1'b0;
        case (op)
            OP_ADD: begin
                y = b;
                c = cin;
            end
            OP_SUB: begin
                y = ~b;
                c = ~cin;
            end
            OP_INC: begin
                y = '0;
                c = 1'b1;
            end
            default: begin
                y = '0;
                c = 1'b0;
            end
        endcase
        sum = {1'b0, x} + {1'b0, y} + (DATA_W+1)'(c);
        s   = sum[DATA_W-1:0];
        cf  = sum[DATA_W];
        of  = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
        if (op == OP_PASS) begin
            s  = a;
            cf = 1'b0;
            of = 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command stage for the 4-bit ALU: valid/ready in, registered result out, with an accumulator.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter logic [3:0]  ACC_INIT = 4'b0000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_use_acc,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_s,
    output logic              out_cf,
    output logic              out_of,
    output logic [DATA_W-1:0] acc,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state;
    state_t            state_nxt;
    alu_cmd_t          cmd_q;
    logic              accept;
    logic [DATA_W-1:0] alu_s;
    logic              alu_of;
    logic              alu_cf;

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake decode from the registered state (out_ready only gates in_ready in DONE).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Latch the command on acceptance; A comes from the pre-clear accumulator when requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
        end else if (accept) begin
            cmd_q.op  <= in_op;
            cmd_q.a   <= in_use_acc ? acc : in_a;
            cmd_q.b   <= in_b;
            cmd_q.cin <= in_cin;
        end
    end

    alu u_alu (
        .a   (cmd_q.a),
        .b   (cmd_q.b),
        .cin (cmd_q.cin),
        .op  (cmd_q.op),
        .s   (alu_s),
        .of  (alu_of),
        .cf  (alu_cf)
    );

    // Capture the ALU result and count the operation at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_s    <= '0;
            out_cf   <= 1'b0;
            out_of   <= 1'b0;
            op_count <= '0;
        end else if (state == ST_EXEC) begin
            out_s  <= alu_s;
            out_cf <= alu_cf;
            out_of <= alu_of;
            if (op_count != {CNT_W{1'b1}}) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    // Accumulator: clear has priority over the EXEC write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= ACC_INIT;
        end else if (clr) begin
            acc <= ACC_INIT;
        end else if (state == ST_EXEC) begin
            acc <= alu_s;
        end
    end

endmodule
